regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Write-side companion of the register file. Buffers register writes from multi-cycle units
//  (load unit, mult/div) in a small FIFO and merges them with the main pipeline's write-back
//  stream. Drives the register file's single write port (we/waddr/wdata).
//  Exposes two lookup ports so decode can forward queued values not yet written.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  DW         32  data width
//  AW         5   register address width
//  STARVE_MAX 8   consecutive blocked cycles with FIFO non-empty before stall_req asserts
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  in_valid   in   1      multi-cycle unit offers a write
//  in_ready   out  1      queue can accept; equals !full
//  in_waddr   in   AW     destination register
//  in_wdata   in   DW     write data
//  pipe_we    in   1      main pipeline write-back valid (highest priority, never back-pressured)
//  pipe_waddr in   AW     pipeline destination
//  pipe_wdata in   DW     pipeline data
//  we         out  1      register file write enable (registered)
//  waddr      out  AW     register file write address (registered)
//  wdata      out  DW     register file write data (registered)
//  lk_addr1   in   AW     forwarding lookup address 1
//  lk_hit1    out  1      youngest pending write to lk_addr1 exists
//  lk_data1   out  DW     its data (0 when no hit)
//  lk_addr2   in   AW     lookup address 2
//  lk_hit2    out  1      as lk_hit1
//  lk_data2   out  DW     as lk_data1
//  stall_req  out  1      request one pipeline write-back bubble (registered)
//  count      out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty; all entry valids cleared; we=0, waddr=0, wdata=0, stall_req=0,
//    count=0, starve counter=0. in_ready=1 during reset. Lookups return hit=0, data=0.
//  Enqueue: in_valid & in_ready. in_waddr==0 is accepted (handshake completes) but never stored.
//  Full: in_ready=0; in_valid is ignored; no entry is overwritten.
//  Output arbitration each cycle, registered into we/waddr/wdata at the next edge (latency 1):
//    pipe_we=1 -> issue pipe write (pipe_waddr==0 -> we=0).
//    else FIFO non-empty -> pop head; issue it if valid, else we=0 (dropped entry, still popped).
//    else we=0.
//  Squash: on pipe_we with pipe_waddr!=0, every stored entry with matching address clears its valid bit
//    (older value must not overwrite newer). An entry enqueued in the same cycle is younger: not squashed.
//  Simultaneous enqueue and pop on a full FIFO: pop frees a slot only next cycle; in_ready stays 0.
//  Pointers wrap modulo DEPTH. count = enqueues - pops and is never >DEPTH or <0.
//  Lookup (combinational): priority is youngest valid FIFO entry, then the output register
//    (we=1 & waddr match). Address 0 never hits.
//  Starvation: counter increments when FIFO non-empty and pipe_we=1; clears on any pop or empty.
//    At STARVE_MAX, stall_req=1 for exactly one cycle, then the counter clears.
//    The pipeline honours stall_req by holding pipe_we=0 for one cycle.
//  Reset mid-operation discards all queued writes. A write already registered on we is not
//    guaranteed to commit.
// TESTING
//  1. Enqueue (r3,0x11),(r4,0x22), no pipe -> we=1 r3 0x11 one cycle after enqueue, then r4 0x22 next cycle; count 0.
//  2. Fill 4 entries, in_valid held -> in_ready=0, 5th write not stored. A pop lets it in on the next cycle.
//  3. Queue (r5,0xAA) while pipe_we holds r6 -> r6 written first; r5 is written after pipe_we drops.
//  4. Queue (r7,0x1); pipe writes (r7,0x2) -> r7=0x2 issued, queued entry dropped with we=0 on its pop; lk_addr1=7 hits 0x2 during output.
//  5. Queue r8 then r8 again (0x5,0x6); lk_addr2=8 -> hit, data 0x6; lk_addr2=0 -> no hit.
//  6. FIFO non-empty, pipe_we=1 for 8 cycles -> stall_req pulses 1 cycle. Async rst mid-queue -> count=0, we=0 immediately.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Write-back merge queue: buffers multi-cycle unit writes, merges them behind the main pipeline's
// write-back stream onto the single register-file write port, and forwards pending values to decode.
module regfile_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_waddr,
    input  logic [DW-1:0]           in_wdata,
    input  logic                    pipe_we,
    input  logic [AW-1:0]           pipe_waddr,
    input  logic [DW-1:0]           pipe_wdata,
    output logic                    we,
    output logic [AW-1:0]           waddr,
    output logic [DW-1:0]           wdata,
    input  logic [AW-1:0]           lk_addr1,
    output logic                    lk_hit1,
    output logic [DW-1:0]           lk_data1,
    input  logic [AW-1:0]           lk_addr2,
    output logic                    lk_hit2,
    output logic [DW-1:0]           lk_data2,
    output logic                    stall_req,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [AW-1:0] ent_addr_d [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [DW-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          stall_req_q, stall_req_d;

    logic full_s, enq_s, pop_s, squash_en_s;

    assign in_ready  = ~full_s;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign stall_req = stall_req_q;
    assign count     = count_q;

    // Handshake qualifiers; an address-0 write completes the handshake but takes no slot.
    always_comb begin
        full_s      = (count_q == CW'(DEPTH));
        enq_s       = in_valid & ~full_s & (in_waddr != {AW{1'b0}});
        pop_s       = ~pipe_we & (count_q != {CW{1'b0}});
        squash_en_s = pipe_we & (pipe_waddr != {AW{1'b0}});
    end

    // FIFO next state: squash older matches first so a same-cycle enqueue stays valid.
    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_vld_d  = ent_vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld_d[i] = ent_vld_q[i] & ~(squash_en_s & (ent_addr_q[i] == pipe_waddr));
        end
        if (pop_s) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (enq_s) begin
            ent_addr_d[wr_ptr_q] = in_waddr;
            ent_data_d[wr_ptr_q] = in_wdata;
            ent_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d             = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        count_d = count_q + CW'(enq_s) - CW'(pop_s);
    end

    // Write-port arbitration: pipeline first, then the FIFO head (squashed heads pop silently).
    always_comb begin
        if (pipe_we) begin
            we_d    = (pipe_waddr != {AW{1'b0}});
            waddr_d = we_d ? pipe_waddr : {AW{1'b0}};
            wdata_d = we_d ? pipe_wdata : {DW{1'b0}};
        end else if (pop_s) begin
            we_d    = ent_vld_q[rd_ptr_q];
            waddr_d = we_d ? ent_addr_q[rd_ptr_q] : {AW{1'b0}};
            wdata_d = we_d ? ent_data_q[rd_ptr_q] : {DW{1'b0}};
        end else begin
            we_d    = 1'b0;
            waddr_d = {AW{1'b0}};
            wdata_d = {DW{1'b0}};
        end
    end

    // Starvation: count blocked cycles with work pending; pulse stall_req and restart at the limit.
    always_comb begin
        if (pipe_we && (count_q != {CW{1'b0}})) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                starve_d    = {SW{1'b0}};
                stall_req_d = 1'b1;
            end else begin
                starve_d    = starve_q + SW'(1'b1);
                stall_req_d = 1'b0;
            end
        end else begin
            starve_d    = {SW{1'b0}};
            stall_req_d = 1'b0;
        end
    end

    // Forwarding lookup: scan oldest to youngest so the youngest valid match wins, then the output reg.
    always_comb begin
        logic m1, m2;
        logic [PW-1:0] idx;
        lk_hit1  = 1'b0;
        lk_data1 = {DW{1'b0}};
        lk_hit2  = 1'b0;
        lk_data2 = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            m1  = (CW'(i) < count_q) & ent_vld_q[idx] & (ent_addr_q[idx] == lk_addr1)
                  & (lk_addr1 != {AW{1'b0}});
            m2  = (CW'(i) < count_q) & ent_vld_q[idx] & (ent_addr_q[idx] == lk_addr2)
                  & (lk_addr2 != {AW{1'b0}});
            lk_data1 = m1 ? ent_data_q[idx] : lk_data1;
            lk_data2 = m2 ? ent_data_q[idx] : lk_data2;
            lk_hit1  = lk_hit1 | m1;
            lk_hit2  = lk_hit2 | m2;
        end
        m1 = ~lk_hit1 & we_q & (waddr_q == lk_addr1) & (lk_addr1 != {AW{1'b0}});
        m2 = ~lk_hit2 & we_q & (waddr_q == lk_addr2) & (lk_addr2 != {AW{1'b0}});
        lk_data1 = m1 ? wdata_q : lk_data1;
        lk_data2 = m2 ? wdata_q : lk_data2;
        lk_hit1  = lk_hit1 | m1;
        lk_hit2  = lk_hit2 | m2;
    end

    // State registers; reset drops everything queued, including a write already on the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= {AW{1'b0}};
                ent_data_q[i] <= {DW{1'b0}};
            end
            ent_vld_q   <= {DEPTH{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            wr_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            starve_q    <= {SW{1'b0}};
            we_q        <= 1'b0;
            waddr_q     <= {AW{1'b0}};
            wdata_q     <= {DW{1'b0}};
            stall_req_q <= 1'b0;
        end else begin
            ent_addr_q  <= ent_addr_d;
            ent_data_q  <= ent_data_d;
            ent_vld_q   <= ent_vld_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            stall_req_q <= stall_req_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: ordering, full handling, priority, squash, forwarding,
// starvation pulse and asynchronous reset.
module tb_regfile_wb_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  lk_addr1;
    logic        lk_hit1;
    logic [31:0] lk_data1;
    logic [4:0]  lk_addr2;
    logic        lk_hit2;
    logic [31:0] lk_data2;
    logic        stall_req;
    logic [2:0]  count;

    int n_total;
    int n_pass;

    regfile_wb_queue #(.DEPTH(4), .DW(32), .AW(5), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .lk_addr1(lk_addr1), .lk_hit1(lk_hit1), .lk_data1(lk_data1),
        .lk_addr2(lk_addr2), .lk_hit2(lk_hit2), .lk_data2(lk_data2),
        .stall_req(stall_req), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b0;
        in_valid = 1'b0; in_waddr = 5'd0; in_wdata = 32'h0;
        pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'h0;
        lk_addr1 = 5'd3; lk_addr2 = 5'd0;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_we", we, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_lk_hit", lk_hit1, 1'b0);
        chk("rst_lk_data", lk_data1, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: two queued writes drain in order
        in_valid = 1'b1; in_waddr = 5'd3; in_wdata = 32'h11;
        tick();
        chk("t1_count_a", count, 3'd1);
        chk("t1_we_a", we, 1'b0);
        in_waddr = 5'd4; in_wdata = 32'h22;
        tick();
        chk("t1_we_b", we, 1'b1);
        chk("t1_waddr_b", waddr, 5'd3);
        chk("t1_wdata_b", wdata, 32'h11);
        chk("t1_count_b", count, 3'd1);
        in_valid = 1'b0;
        tick();
        chk("t1_we_c", we, 1'b1);
        chk("t1_waddr_c", waddr, 5'd4);
        chk("t1_wdata_c", wdata, 32'h22);
        chk("t1_count_c", count, 3'd0);
        tick();
        chk("t1_we_d", we, 1'b0);

        // 2: fill behind a pipe write to r0 (issues we=0, blocks pops)
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_waddr = 5'(10 + i);
            in_wdata = 32'hA0 + 32'(i);
            tick();
            if (i == 0) chk("t2_pipe_r0_we", we, 1'b0);
        end
        chk("t2_full_count", count, 3'd4);
        chk("t2_full_ready", in_ready, 1'b0);
        in_waddr = 5'd14; in_wdata = 32'hA4;
        tick();
        chk("t2_5th_ignored", count, 3'd4);
        pipe_we = 1'b0;
        tick();
        chk("t2_pop_count", count, 3'd3);
        chk("t2_pop_ready", in_ready, 1'b1);
        chk("t2_pop_waddr", waddr, 5'd10);
        tick();
        in_valid = 1'b0;
        chk("t2_enq_count", count, 3'd3);
        chk("t2_pop2_wdata", wdata, 32'hA1);
        tick();
        tick();
        tick();
        chk("t2_last_waddr", waddr, 5'd14);
        chk("t2_last_wdata", wdata, 32'hA4);
        chk("t2_empty", count, 3'd0);

        // Address-0 enqueue is accepted but not stored
        in_valid = 1'b1; in_waddr = 5'd0; in_wdata = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("r0_not_stored", count, 3'd0);

        // 3: pipeline write has priority over the queue
        in_valid = 1'b1; in_waddr = 5'd5; in_wdata = 32'hAA;
        pipe_we = 1'b1; pipe_waddr = 5'd6; pipe_wdata = 32'h66;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_pipe_waddr", waddr, 5'd6);
        chk("t3_pipe_wdata", wdata, 32'h66);
        chk("t3_count", count, 3'd1);
        pipe_we = 1'b0;
        tick();
        chk("t3_q_waddr", waddr, 5'd5);
        chk("t3_q_wdata", wdata, 32'hAA);
        chk("t3_count_end", count, 3'd0);

        // 4: squash of an older queued write by a pipeline write
        in_valid = 1'b1; in_waddr = 5'd7; in_wdata = 32'h1;
        tick();
        in_valid = 1'b0;
        lk_addr1 = 5'd7;
        pipe_we = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h2;
        #1;
        chk("t4_lk_fifo_data", lk_data1, 32'h1);
        tick();
        chk("t4_we", we, 1'b1);
        chk("t4_wdata", wdata, 32'h2);
        chk("t4_lk_hit", lk_hit1, 1'b1);
        chk("t4_lk_out_data", lk_data1, 32'h2);
        pipe_we = 1'b0;
        tick();
        chk("t4_dropped_we", we, 1'b0);
        chk("t4_count", count, 3'd0);
        chk("t4_lk_nohit", lk_hit1, 1'b0);

        // 5: youngest duplicate wins the lookup
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h0;
        in_valid = 1'b1; in_waddr = 5'd8; in_wdata = 32'h5;
        tick();
        in_wdata = 32'h6;
        tick();
        in_valid = 1'b0;
        lk_addr2 = 5'd8;
        #1;
        chk("t5_count", count, 3'd2);
        chk("t5_hit", lk_hit2, 1'b1);
        chk("t5_data", lk_data2, 32'h6);
        lk_addr2 = 5'd0;
        #1;
        chk("t5_r0_hit", lk_hit2, 1'b0);
        chk("t5_r0_data", lk_data2, 32'h0);
        lk_addr2 = 5'd8;
        pipe_we = 1'b0;
        tick();
        chk("t5_drain_wdata", wdata, 32'h5);
        chk("t5_fifo_over_out", lk_data2, 32'h6);
        tick();
        chk("t5_drain2_wdata", wdata, 32'h6);
        tick();

        // 6: starvation pulse, then asynchronous reset mid-queue
        in_valid = 1'b1; in_waddr = 5'd9; in_wdata = 32'h99;
        tick();
        in_valid = 1'b0;
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
        for (int i = 0; i < 7; i++) tick();
        chk("t6_stall_pre", stall_req, 1'b0);
        tick();
        chk("t6_stall_pulse", stall_req, 1'b1);
        tick();
        chk("t6_stall_drop", stall_req, 1'b0);
        chk("t6_count_held", count, 3'd1);
        lk_addr1 = 5'd9;
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_count", count, 3'd0);
        chk("t6_rst_we", we, 1'b0);
        chk("t6_rst_lk", lk_hit1, 1'b0);
        pipe_we = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
